alu_exec_unit: RTL and testbench

- Integer execution unit on the consumer side of the reservation-station dispatch interface.
- Accepts one dispatched RV32I ALU/branch/jump op per cycle. Computes the result and the redirect information.
- Buffers results in a small in-order queue.
- Broadcasts the queue head on the ALU result bus to the RS, LSB and ROB, and pops it when the CDB arbiter grants.

---
 rtl/alu_exec_unit_pkg.sv | 40 ++++
 rtl/alu_exec_unit_core.sv | 76 +++++++
 rtl/alu_exec_unit.sv | 116 +++++++++++
 tb/tb_alu_exec_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared RV32I opcode/funct3 encodings and the result record used by the ALU execution unit.
package alu_exec_unit_pkg;

    localparam int ROB_POS_WID = 4;

    localparam logic [6:0] OP_R_TYPE     = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE     = 7'b0010011;
    localparam logic [6:0] OP_SB_TYPE    = 7'b1100011;
    localparam logic [6:0] OP_LUI_TYPE   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC_TYPE = 7'b0010111;
    localparam logic [6:0] OP_UJ_TYPE    = 7'b1101111;
    localparam logic [6:0] OP_JALR_TYPE  = 7'b1100111;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_f3_e;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_f3_e;

    typedef struct packed {
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
    } alu_res_t;

endpackage

// File: rtl/alu_exec_unit_core.sv
// Combinational RV32I ALU/branch/jump evaluation: dispatch fields in, {val, jump, pc} out.
module alu_core
    import alu_exec_unit_pkg::*;
(
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7,
    output logic [31:0] val,
    output logic        jump,
    output logic [31:0] target
);

    logic [31:0] op_b;
    logic [31:0] alu_out;
    logic        take;
    logic [4:0]  shamt;

    always_comb begin
        op_b  = (opcode == OP_R_TYPE) ? val2 : imm;
        shamt = op_b[4:0];
        case (funct3)
            F3_ADD:  alu_out = (opcode == OP_R_TYPE && funct7) ? val1 - op_b : val1 + op_b;
            F3_SLL:  alu_out = val1 << shamt;
            F3_SLT:  alu_out = {31'b0, $signed(val1) < $signed(op_b)};
            F3_SLTU: alu_out = {31'b0, val1 < op_b};
            F3_XOR:  alu_out = val1 ^ op_b;
            F3_SR:   alu_out = funct7 ? 32'($signed(val1) >>> shamt) : val1 >> shamt;
            F3_OR:   alu_out = val1 | op_b;
            F3_AND:  alu_out = val1 & op_b;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_BEQ:  take = (val1 == val2);
            F3_BNE:  take = (val1 != val2);
            F3_BLT:  take = ($signed(val1) <  $signed(val2));
            F3_BGE:  take = ($signed(val1) >= $signed(val2));
            F3_BLTU: take = (val1 <  val2);
            F3_BGEU: take = (val1 >= val2);
            default: take = 1'b0;
        endcase
    end

    // Non-control ops report no redirect target.
    always_comb begin
        val    = '0;
        jump   = 1'b0;
        target = '0;
        case (opcode)
            OP_R_TYPE, OP_I_TYPE: val = alu_out;
            OP_LUI_TYPE:          val = imm;
            OP_AUIPC_TYPE:        val = pc + imm;
            OP_UJ_TYPE: begin
                val    = pc + 32'd4;
                target = pc + imm;
            end
            OP_JALR_TYPE: begin
                val    = pc + 32'd4;
                jump   = 1'b1;
                target = (val1 + imm) & ~32'd1;
            end
            OP_SB_TYPE: begin
                jump   = take;
                target = pc + imm;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Integer execution unit: evaluates dispatched ops and holds results in an in-order queue for the CDB.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int ROB_POS_W = ROB_POS_WID,
    parameter int QDEPTH    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 alu_en,
    input  logic [31:0]          alu_val1,
    input  logic [31:0]          alu_val2,
    input  logic [31:0]          alu_imm,
    input  logic [31:0]          alu_pc,
    input  logic [6:0]           alu_opcode,
    input  logic [2:0]           alu_funct3,
    input  logic                 alu_funct7,
    input  logic [ROB_POS_W-1:0] alu_rob_pos,
    output logic                 alu_ready,
    output logic                 alu_result,
    output logic [31:0]          alu_result_val,
    output logic [ROB_POS_W-1:0] alu_result_rob_pos,
    output logic                 alu_result_jump,
    output logic [31:0]          alu_result_pc,
    input  logic                 cdb_grant,
    output logic                 alu_overflow
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;
    alu_res_t             q_res [QDEPTH];
    logic [ROB_POS_W-1:0] q_rob [QDEPTH];

    alu_res_t core_res;
    logic     full;
    logic     empty;
    logic     push;
    logic     pop;

    alu_core u_core (
        .val1   (alu_val1),
        .val2   (alu_val2),
        .imm    (alu_imm),
        .pc     (alu_pc),
        .opcode (alu_opcode),
        .funct3 (alu_funct3),
        .funct7 (alu_funct7),
        .val    (core_res.val),
        .jump   (core_res.jump),
        .target (core_res.pc)
    );

    // Fullness comes from the registered count, so a same-cycle grant cannot make room.
    always_comb begin
        full  = (count == CNT_W'(QDEPTH));
        empty = (count == '0);
        push  = alu_en && !full;
        pop   = cdb_grant && !empty;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            alu_overflow <= 1'b0;
        end else if (rdy) begin
            if (rollback) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push)
                    tail <= tail + 1'b1;
                if (pop)
                    head <= head + 1'b1;
                if (push && !pop)
                    count <= count + 1'b1;
                else if (!push && pop)
                    count <= count - 1'b1;
                if (alu_en && full)
                    alu_overflow <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (rdy && !rollback && push) begin
            q_res[tail] <= core_res;
            q_rob[tail] <= alu_rob_pos;
        end
    end

    always_comb begin
        alu_ready          = !full;
        alu_result         = !empty;
        alu_result_val     = '0;
        alu_result_jump    = 1'b0;
        alu_result_pc      = '0;
        alu_result_rob_pos = '0;
        if (!empty) begin
            alu_result_val     = q_res[head].val;
            alu_result_jump    = q_res[head].jump;
            alu_result_pc      = q_res[head].pc;
            alu_result_rob_pos = q_rob[head];
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed literal cases plus randomized traffic against a queue model.
module tb_alu_exec_unit;

    localparam int RW = 4;
    localparam int QD = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          rollback;
    logic          alu_en;
    logic [31:0]   alu_val1;
    logic [31:0]   alu_val2;
    logic [31:0]   alu_imm;
    logic [31:0]   alu_pc;
    logic [6:0]    alu_opcode;
    logic [2:0]    alu_funct3;
    logic          alu_funct7;
    logic [RW-1:0] alu_rob_pos;
    logic          alu_ready;
    logic          alu_result;
    logic [31:0]   alu_result_val;
    logic [RW-1:0] alu_result_rob_pos;
    logic          alu_result_jump;
    logic [31:0]   alu_result_pc;
    logic          cdb_grant;
    logic          alu_overflow;

    alu_exec_unit #(.ROB_POS_W(RW), .QDEPTH(QD)) dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .rollback           (rollback),
        .alu_en             (alu_en),
        .alu_val1           (alu_val1),
        .alu_val2           (alu_val2),
        .alu_imm            (alu_imm),
        .alu_pc             (alu_pc),
        .alu_opcode         (alu_opcode),
        .alu_funct3         (alu_funct3),
        .alu_funct7         (alu_funct7),
        .alu_rob_pos        (alu_rob_pos),
        .alu_ready          (alu_ready),
        .alu_result         (alu_result),
        .alu_result_val     (alu_result_val),
        .alu_result_rob_pos (alu_result_rob_pos),
        .alu_result_jump    (alu_result_jump),
        .alu_result_pc      (alu_result_pc),
        .cdb_grant          (cdb_grant),
        .alu_overflow       (alu_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   val;
        logic          jump;
        logic [31:0]   pc;
        logic [RW-1:0] rob;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf = 1'b0;
    bit   live  = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed_lt(input logic [31:0] a, input logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic ent_t ref_exec(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                      input logic [31:0] a, input logic [31:0] r2,
                                      input logic [31:0] imm, input logic [31:0] pc,
                                      input logic [RW-1:0] rob);
        ent_t        e;
        logic [31:0] b;
        int          sh;
        e.val = 0; e.jump = 0; e.pc = 0; e.rob = rob;
        b  = (opc == 7'h33) ? r2 : imm;
        sh = int'(b[4:0]);
        case (opc)
            7'h33, 7'h13: begin
                case (f3)
                    3'd0: e.val = (opc == 7'h33 && f7) ? a + ~b + 32'd1 : a + b;
                    3'd1: e.val = a << sh;
                    3'd2: e.val = {31'b0, signed_lt(a, b)};
                    3'd3: e.val = {31'b0, a < b};
                    3'd4: e.val = a ^ b;
                    3'd5: begin
                        e.val = a >> sh;
                        if (f7 && a[31]) e.val = e.val | ~(32'hFFFF_FFFF >> sh);
                    end
                    3'd6: e.val = a | b;
                    default: e.val = a & b;
                endcase
            end
            7'h37: e.val = imm;
            7'h17: e.val = pc + imm;
            7'h6F: begin e.val = pc + 4; e.pc = pc + imm; end
            7'h67: begin e.val = pc + 4; e.jump = 1; e.pc = (a + imm) & 32'hFFFF_FFFE; end
            7'h63: begin
                e.pc = pc + imm;
                case (f3)
                    3'd0: e.jump = (a == r2);
                    3'd1: e.jump = (a != r2);
                    3'd4: e.jump = signed_lt(a, r2);
                    3'd5: e.jump = !signed_lt(a, r2);
                    3'd6: e.jump = (a < r2);
                    3'd7: e.jump = (a >= r2);
                    default: e.jump = 0;
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_update();
        bit full;
        if (!rdy) return;
        if (rollback) begin
            mq.delete();
            return;
        end
        full = (mq.size() == QD);
        if (alu_en && full) m_ovf = 1'b1;
        if (cdb_grant && mq.size() > 0) void'(mq.pop_front());
        if (alu_en && !full)
            mq.push_back(ref_exec(alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
                                  alu_imm, alu_pc, alu_rob_pos));
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("result_valid", 32'(alu_result), 32'(mq.size() > 0));
            chk("ready", 32'(alu_ready), 32'(mq.size() < QD));
            chk("overflow", 32'(alu_overflow), 32'(m_ovf));
            if (mq.size() > 0) begin
                chk("val", alu_result_val, mq[0].val);
                chk("jump", 32'(alu_result_jump), 32'(mq[0].jump));
                chk("pc", alu_result_pc, mq[0].pc);
                chk("rob_pos", 32'(alu_result_rob_pos), 32'(mq[0].rob));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_op(input logic en, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [RW-1:0] rob);
        alu_en = en; alu_opcode = opc; alu_funct3 = f3; alu_funct7 = f7;
        alu_val1 = v1; alu_val2 = v2; alu_imm = imm; alu_pc = pc; alu_rob_pos = rob;
    endtask

    task automatic one_op(input string name, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic [31:0] v1, input logic [31:0] v2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [RW-1:0] rob,
                          input logic [31:0] ev, input logic ej, input logic [31:0] epc);
        set_op(1'b1, opc, f3, f7, v1, v2, imm, pc, rob);
        cdb_grant = 1'b0;
        tick();
        alu_en = 1'b0;
        chk({name, "_valid"}, 32'(alu_result), 32'd1);
        chk({name, "_val"}, alu_result_val, ev);
        chk({name, "_jump"}, 32'(alu_result_jump), 32'(ej));
        chk({name, "_pc"}, alu_result_pc, epc);
        chk({name, "_rob"}, 32'(alu_result_rob_pos), 32'(rob));
        cdb_grant = 1'b1;
        tick();
        chk({name, "_popped"}, 32'(alu_result), 32'd0);
        cdb_grant = 1'b0;
    endtask

    initial begin
        logic [6:0] opcs [8];
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h00};
        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; cdb_grant = 1'b0;
        set_op(1'b0, 7'h0, 3'h0, 1'b0, 0, 0, 0, 0, '0);
        #12;
        chk("rst_result", 32'(alu_result), 32'd0);
        chk("rst_val", alu_result_val, 32'd0);
        chk("rst_overflow", 32'(alu_overflow), 32'd0);
        chk("rst_ready", 32'(alu_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        live = 1'b1;

        one_op("add",  7'h33, 3'd0, 1'b0, 32'd5, 32'd7, 0, 0, 4'd3, 32'd12, 1'b0, 32'd0);
        one_op("sra",  7'h33, 3'd5, 1'b1, 32'h8000_0010, 32'd4, 0, 0, 4'd1, 32'hF800_0001, 1'b0, 0);
        one_op("srl",  7'h33, 3'd5, 1'b0, 32'h8000_0010, 32'd4, 0, 0, 4'd2, 32'h0800_0001, 1'b0, 0);
        one_op("sltu", 7'h33, 3'd3, 1'b0, 32'd1, 32'hFFFF_FFFF, 0, 0, 4'd4, 32'd1, 1'b0, 0);
        one_op("slt",  7'h33, 3'd2, 1'b0, 32'd1, 32'hFFFF_FFFF, 0, 0, 4'd5, 32'd0, 1'b0, 0);
        one_op("bne",  7'h63, 3'd1, 1'b0, 32'd1, 32'd2, 32'h20, 32'h100, 4'd6, 0, 1'b1, 32'h120);
        one_op("beq",  7'h63, 3'd0, 1'b0, 32'd1, 32'd2, 32'h20, 32'h100, 4'd7, 0, 1'b0, 32'h120);
        one_op("jalr", 7'h67, 3'd0, 1'b0, 32'h203, 0, 0, 32'h40, 4'd8, 32'h44, 1'b1, 32'h202);

        // Backpressure: fill, overflow on a third dispatch, then drain in order.
        set_op(1'b1, 7'h33, 3'd0, 1'b0, 32'd1, 32'd1, 0, 0, 4'd1);
        tick();
        set_op(1'b1, 7'h33, 3'd0, 1'b0, 32'd2, 32'd2, 0, 0, 4'd2);
        tick();
        chk("bp_ready", 32'(alu_ready), 32'd0);
        set_op(1'b1, 7'h33, 3'd0, 1'b0, 32'd9, 32'd9, 0, 0, 4'd5);
        tick();
        chk("bp_overflow", 32'(alu_overflow), 32'd1);
        alu_en = 1'b0; cdb_grant = 1'b1;
        chk("bp_head0", alu_result_val, 32'd2);
        tick();
        chk("bp_head1", alu_result_val, 32'd4);
        chk("bp_head1_rob", 32'(alu_result_rob_pos), 32'd2);
        tick();
        chk("bp_empty", 32'(alu_result), 32'd0);

        // Simultaneous push/pop at count=1, then rollback while full.
        cdb_grant = 1'b0;
        set_op(1'b1, 7'h13, 3'd0, 1'b0, 32'd10, 0, 32'd1, 0, 4'd9);
        tick();
        set_op(1'b1, 7'h13, 3'd0, 1'b0, 32'd20, 0, 32'd2, 0, 4'd10);
        cdb_grant = 1'b1;
        tick();
        chk("pp_head", alu_result_val, 32'd22);
        chk("pp_ready", 32'(alu_ready), 32'd1);
        set_op(1'b1, 7'h37, 3'd0, 1'b0, 0, 0, 32'h1234_5000, 0, 4'd11);
        cdb_grant = 1'b0;
        tick();
        chk("pp_full", 32'(alu_ready), 32'd0);
        rollback = 1'b1; cdb_grant = 1'b1;
        tick();
        rollback = 1'b0; alu_en = 1'b0; cdb_grant = 1'b0;
        chk("rb_result", 32'(alu_result), 32'd0);
        chk("rb_ready", 32'(alu_ready), 32'd1);

        // Freeze with rdy low while a grant, dispatch and rollback are all asserted.
        set_op(1'b1, 7'h17, 3'd0, 1'b0, 0, 0, 32'h10, 32'h300, 4'd6);
        tick();
        rdy = 1'b0; cdb_grant = 1'b1; rollback = 1'b1;
        repeat (3) begin
            tick();
            chk("frz_valid", 32'(alu_result), 32'd1);
            chk("frz_val", alu_result_val, 32'h310);
        end
        rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0;
        tick();
        chk("frz_pop", 32'(alu_result), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] opc;
            opc = opcs[$urandom_range(7)];
            if (opc == 7'h00) opc = 7'($urandom);
            set_op($urandom_range(99) < 60, opc, 3'($urandom), 1'($urandom),
                   ($urandom_range(3) == 0) ? 32'h8000_0000 >> $urandom_range(31) : $urandom,
                   ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom,
                   $urandom, $urandom, 4'($urandom));
            rdy       = $urandom_range(9) != 0;
            rollback  = $urandom_range(39) == 0;
            cdb_grant = $urandom_range(1) == 1;
            tick();
        end
        rdy = 1'b1; rollback = 1'b0; alu_en = 1'b0; cdb_grant = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
